serial_add_ctrl: RTL and testbench

- Bit-serial N-bit adder controller. Time-multiplexes one 1-bit full adder (the team's structural full-adder cell, instantiated inside) across WIDTH cycles.
- Operand and sum shift registers, a carry flop and a bit counter are sequenced by a 3-state FSM.
- Sits in the arithmetic datapath as a low-area alternative to a ripple-carry adder. Uses a start/busy/done handshake to the requesting logic.

---
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Handshake and operand/result bundle for serial_add_ctrl.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (p & ci);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             busy_c;
  logic             done_c;

  // Subtraction is a + ~b + 1, so only the B operand and initial carry differ.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  full_adder_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // sum_sh and carry double as the result registers; they only change on an accepted start or in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= b_load;
            carry  <= c_load;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_co;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.sum  = sum_sh;
  assign bus.cout = carry;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, hand-written corner sequences and random ops vs. an arithmetic model.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic unused_sub;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic sub);
    bus.start = st;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub   = sub;
`else
    unused_sub = sub;
`endif
  endtask

  // Reference: plain arithmetic on the true values, {cout, sum}.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic cin, input logic sub);
    longint t;
    if (sub) begin
      t = longint'(a) - longint'(b);
      return {(a >= b), t[WIDTH-1:0]};
    end
    t = longint'(a) + longint'(b) + longint'(cin);
    return t[WIDTH:0];
  endfunction

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int busy_cnt;
    int cyc;
    busy_cnt = 0;
    cyc      = 0;
    applyStimulus(1'b1, a, b, cin, sub);
    step();
    applyStimulus(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    while (!bus.done && cyc < 4 * WIDTH) begin
      if (bus.busy) busy_cnt++;
      step();
      cyc++;
    end
    checkOutput({name, "_done_seen"}, 64'(bus.done), 64'd1);
    checkOutput({name, "_busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
    checkOutput({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    checkOutput({name, "_sum"}, 64'(bus.sum), 64'(exp_sum));
    checkOutput({name, "_cout"}, 64'(bus.cout), 64'(exp_cout));
    step();
    checkOutput({name, "_done_pulse"}, 64'(bus.done), 64'd0);
    checkOutput({name, "_sum_hold"}, 64'(bus.sum), 64'(exp_sum));
    checkOutput({name, "_cout_hold"}, 64'(bus.cout), 64'(exp_cout));
  endtask

  vec_t vecs[6];

  initial begin
    int done_cnt;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic rc;
    logic rs;
    logic [WIDTH:0] exp;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};

    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    step();
    step();
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_done", 64'(bus.done), 64'd0);
    checkOutput("reset_sum", 64'(bus.sum), 64'h00);
    checkOutput("reset_cout", 64'(bus.cout), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].exp_sum, vecs[i].exp_cout);

    // start re-asserted in RUN cycles 3 and 6 and in the DONE cycle must be ignored
    done_cnt = 0;
    applyStimulus(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    step();
    for (int cyc = 1; cyc <= WIDTH + 3; cyc++) begin
      if (cyc == WIDTH + 1)
        checkOutput("ignore_done_cycle", 64'(bus.done), 64'd1);
      if (bus.done) begin
        done_cnt++;
        checkOutput("ignore_sum", 64'(bus.sum), 64'h30);
        checkOutput("ignore_cout", 64'(bus.cout), 64'd0);
      end
      if (cyc == 3 || cyc == 6 || cyc == WIDTH + 1)
        applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
      else
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
    end
    checkOutput("ignore_done_count", 64'(done_cnt), 64'd1);
    checkOutput("ignore_idle_busy", 64'(bus.busy), 64'd0);
    checkOutput("ignore_sum_hold", 64'(bus.sum), 64'h30);

    // reset in RUN cycle 4 abandons the operation
    applyStimulus(1'b1, 8'h77, 8'h11, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
    checkOutput("midrst_done", 64'(bus.done), 64'd0);
    checkOutput("midrst_sum", 64'(bus.sum), 64'h00);
    checkOutput("midrst_cout", 64'(bus.cout), 64'd0);
    done_cnt = 0;
    for (int cyc = 0; cyc < WIDTH + 2; cyc++) begin
      if (bus.done || bus.busy) done_cnt++;
      step();
    end
    checkOutput("midrst_no_activity", 64'(done_cnt), 64'd0);
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_5_3", 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1);
    run_op("sub_3_5", 8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0);
    run_op("sub_cin_ignored", 8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1);
    run_op("sub_equal", 8'hA5, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b1);
`endif

    for (int i = 0; i < 24; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      exp = model(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, exp[WIDTH-1:0], exp[WIDTH]);
      if ((i % 3) == 0) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
